// File: rtl/dmem_io_pkg.sv
// dmem_io_pkg: address map and STATUS layout shared by dmem_io and its bench
package dmem_io_pkg;
  localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;
  localparam logic [31:0] CYCLES_ADDR = 32'h8000_0008;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_CNT   = 4;
  function automatic logic [31:0] status_word(logic full, logic empty, logic ovf, logic [3:0] cnt);
    logic [31:0] s;
    s = '0;
    s[ST_FULL] = full;
    s[ST_EMPTY] = empty;
    s[ST_OVF] = ovf;
    s[ST_CNT +: 4] = cnt;
    return s;
  endfunction
endpackage

// File: rtl/dmem_io_txq_fifo.sv
// txq_fifo: byte FIFO feeding the TX port; a full push is taken when a pop frees a slot on the same edge
module txq_fifo #(
  parameter int TXQ_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [7:0]                   din_i,
  input  logic                         pop_i,
  output logic [7:0]                   dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(TXQ_DEPTH):0]   count_o,
  output logic                         accept_o
);
  localparam int AW = $clog2(TXQ_DEPTH);
  logic [7:0] mem [TXQ_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [7:0] last_q;
  logic pop;
  assign full_o = cnt_q == (AW+1)'(TXQ_DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign pop = pop_i & ~empty_o;
  assign accept_o = push_i & (~full_o | pop);
  // last_q keeps tx_data stable once the queue drains
  assign dout_o = empty_o ? last_q : mem[rd_q];
  always_comb begin
    rd_d = rd_q + AW'(pop);
    wr_d = wr_q + AW'(accept_o);
    cnt_d = cnt_q + (AW+1)'(accept_o) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      if (pop) last_q <= mem[rd_q];
    end
  always_ff @(posedge clk)
    if (accept_o) mem[wr_q] <= din_i;
endmodule

// File: rtl/dmem_io.sv
// dmem_io: CPU data port with zero-latency RAM, TX byte FIFO, STATUS and a free-running cycle counter
module dmem_io
  import dmem_io_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int TXQ_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int QW = $clog2(TXQ_DEPTH);
  logic [31:0] mem [RAM_WORDS];
  logic [31:0] cyc_q, cyc_d, cnt_w;
  logic ovf_q, ovf_d;
  logic ram_sel, txd_sel, st_sel, cyc_sel, push, pop, full, empty, accept;
  logic [QW:0] count;
  logic [3:0] cnt4;
  logic [AW-1:0] idx;
  assign idx = daddr[AW+1:2];
  assign ram_sel = (daddr >> (AW + 2)) == 32'd0;
  assign txd_sel = daddr == TXDATA_ADDR;
  assign st_sel = daddr == STATUS_ADDR;
  assign cyc_sel = daddr == CYCLES_ADDR;
  assign push = txd_sel & dwe[0];
  assign pop = tx_valid & tx_ready;
  assign tx_valid = ~empty;
  assign cnt_w = 32'(count);
  assign cnt4 = cnt_w > 32'd15 ? 4'hF : cnt_w[3:0];
  txq_fifo #(.TXQ_DEPTH(TXQ_DEPTH)) u_txq (
    .clk(clk), .rst_i(reset), .push_i(push), .din_i(dwdata[7:0]), .pop_i(pop),
    .dout_o(tx_data), .full_o(full), .empty_o(empty), .count_o(count), .accept_o(accept)
  );
  always_comb begin
    drdata = ram_sel ? mem[idx] : st_sel ? status_word(full, empty, ovf_q, cnt4) : cyc_sel ? cyc_q : 32'd0;
    ovf_d = (push & ~accept) ? 1'b1 : (st_sel & dwe[0] & dwdata[ST_OVF]) ? 1'b0 : ovf_q;
    cyc_d = (cyc_sel & |dwe) ? 32'd0 : cyc_q + 32'd1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ovf_q <= 1'b0;
      cyc_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      cyc_q <= cyc_d;
    end
  // RAM has no reset value; the reset term only blocks stores made while reset is held
  always_ff @(posedge clk or posedge reset)
    if (!reset && ram_sel)
      for (int i = 0; i < 4; i++)
        if (dwe[i]) mem[idx][8*i +: 8] <= dwdata[8*i +: 8];
endmodule
